// File: rtl/axi4_lite_rr_arbiter.sv
// Two-master AXI4-Lite round-robin arbiter in front of one slave.
// One whole transaction (AR->R or AW->W->B) is granted at a time.
module axi4_lite_rr_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_arvalid,
    output logic [1:0]          m_arready,
    input  logic [2*ADDR_W-1:0] m_araddr,
    input  logic [1:0]          m_awvalid,
    output logic [1:0]          m_awready,
    input  logic [2*ADDR_W-1:0] m_awaddr,
    input  logic [1:0]          m_wvalid,
    output logic [1:0]          m_wready,
    input  logic [2*DATA_W-1:0] m_wdata,
    output logic [1:0]          m_bvalid,
    input  logic [1:0]          m_bready,
    output logic [1:0]          m_bresp,
    output logic [1:0]          m_rvalid,
    input  logic [1:0]          m_rready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_rresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                gnt,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic              gnt_nx;
    logic              last;
    logic              done;
    logic [1:0]        req;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] araddr_g;
    logic [ADDR_W-1:0] awaddr_g;
    logic [DATA_W-1:0] wdata_g;

    assign req      = m_arvalid | m_awvalid;
    assign sel      = gnt ? 2'b10 : 2'b01;
    assign araddr_g = gnt ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
    assign awaddr_g = gnt ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    assign wdata_g  = gnt ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            if (done) begin
                last <= gnt;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        done      = 1'b0;
        m_arready = 2'b00;
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        m_rvalid  = 2'b00;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_bresp   = 2'b00;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_rready  = 1'b0;
        s_bready  = 1'b0;
        unique case (state)
            IDLE: begin
                // Contention goes to the master that did not finish last.
                if (|req) begin
                    gnt_nx   = (&req) ? ~last : req[1];
                    state_nx = m_arvalid[gnt_nx] ? RADDR : WADDR;
                end
            end
            RADDR: begin
                s_arvalid = m_arvalid[gnt];
                s_araddr  = araddr_g;
                m_arready = {2{s_arready}} & sel;
                if (s_arvalid && s_arready) begin
                    state_nx = RDATA;
                end
            end
            RDATA: begin
                m_rvalid = {2{s_rvalid}} & sel;
                s_rready = m_rready[gnt];
                m_rdata  = s_rdata;
                m_rresp  = s_rresp;
                if (s_rvalid && s_rready) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            WADDR: begin
                s_awvalid = m_awvalid[gnt];
                s_awaddr  = awaddr_g;
                m_awready = {2{s_awready}} & sel;
                if (s_awvalid && s_awready) begin
                    state_nx = WDATA;
                end
            end
            WDATA: begin
                s_wvalid = m_wvalid[gnt];
                s_wdata  = wdata_g;
                m_wready = {2{s_wready}} & sel;
                if (s_wvalid && s_wready) begin
                    state_nx = WRESP;
                end
            end
            WRESP: begin
                m_bvalid = {2{s_bvalid}} & sel;
                s_bready = m_bready[gnt];
                m_bresp  = s_bresp;
                if (s_bvalid && s_bready) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Bench for axi4_lite_rr_arbiter: directed table, hand sequences,
// and random traffic against a transaction-level model with RAM slave.
module tb_axi4_lite_rr_arbiter;

    localparam int P_IDLE = 0;
    localparam int P_AR   = 1;
    localparam int P_R    = 2;
    localparam int P_AW   = 3;
    localparam int P_W    = 4;
    localparam int P_B    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_arvalid, m_arready, m_awvalid, m_awready;
    logic [1:0]  m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rvalid, m_rready, m_rresp, m_bresp;
    logic [15:0] m_araddr, m_awaddr;
    logic [63:0] m_wdata;
    logic [31:0] m_rdata;
    logic        s_arvalid, s_arready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_rvalid, s_rready;
    logic [7:0]  s_araddr, s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    logic [1:0]  s_bresp, s_rresp;
    logic        gnt, busy;

    axi4_lite_rr_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp),
        .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Master-side intent, arbitration memory and two RAM images.
    logic [1:0]  pend_ar, pend_aw, pend_w;
    logic [7:0]  ar_a [2];
    logic [7:0]  aw_a [2];
    logic [31:0] w_d [2];
    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];
    logic [7:0]  slv_ra, slv_wa;
    int          last_m, gnt_m;
    int          total, bad;

    typedef struct {
        logic [1:0]  ar;
        logic [1:0]  aw;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          bh;
        int          eg;
        bit          ewr;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_m();
        m_arvalid = pend_ar;
        m_awvalid = pend_aw;
        m_wvalid  = pend_w;
        m_araddr  = {ar_a[1], ar_a[0]};
        m_awaddr  = {aw_a[1], aw_a[0]};
        m_wdata   = {w_d[1], w_d[0]};
    endtask

    function automatic logic [16:0] obs();
        return {m_arready, m_awready, m_wready, m_bvalid, m_rvalid,
                s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                busy, gnt};
    endfunction

    function automatic logic [16:0] expv(input int ph, input int w);
        logic [1:0] oh;
        logic [1:0] mar, maw, mw, mb, mr;
        logic       sar, saw, sw, sr, sb;
        oh  = (w == 1) ? 2'b10 : 2'b01;
        mar = (ph == P_AR && s_arready) ? oh : 2'b00;
        maw = (ph == P_AW && s_awready) ? oh : 2'b00;
        mw  = (ph == P_W && s_wready) ? oh : 2'b00;
        mb  = (ph == P_B && s_bvalid) ? oh : 2'b00;
        mr  = (ph == P_R && s_rvalid) ? oh : 2'b00;
        sar = (ph == P_AR) ? m_arvalid[w] : 1'b0;
        saw = (ph == P_AW) ? m_awvalid[w] : 1'b0;
        sw  = (ph == P_W) ? m_wvalid[w] : 1'b0;
        sr  = (ph == P_R) ? m_rready[w] : 1'b0;
        sb  = (ph == P_B) ? m_bready[w] : 1'b0;
        return {mar, maw, mw, mb, mr, sar, saw, sw, sr, sb,
                (ph != P_IDLE), 1'(gnt_m)};
    endfunction

    // One clock of a transaction phase with randomized slave/ready inputs.
    task automatic cyc(input int ph, input int w, input bit hold_b,
                       output bit hs);
        @(negedge clk);
        s_arready = 1'($urandom);
        s_awready = 1'($urandom);
        s_wready  = 1'($urandom);
        s_rvalid  = 1'($urandom);
        s_bvalid  = 1'($urandom);
        s_rresp   = 2'($urandom);
        s_bresp   = 2'($urandom);
        m_rready  = 2'($urandom);
        m_bready  = 2'($urandom);
        s_rdata   = slv_mem[slv_ra];
        if (hold_b) begin
            s_bvalid    = 1'b1;
            m_bready[w] = 1'b0;
        end
        #1;
        chk($sformatf("hs_vec ph%0d", ph), 64'(obs()), 64'(expv(ph, w)));
        hs = 1'b0;
        case (ph)
            P_AR: begin
                chk("araddr", 64'(s_araddr), 64'(ar_a[w]));
                hs = s_arready;
                if (hs) slv_ra = s_araddr;
            end
            P_R: begin
                if (s_rvalid) begin
                    chk("rdata", 64'(m_rdata), 64'(ref_mem[ar_a[w]]));
                    chk("rresp", 64'(m_rresp), 64'(s_rresp));
                end
                hs = s_rvalid & m_rready[w];
            end
            P_AW: begin
                chk("awaddr", 64'(s_awaddr), 64'(aw_a[w]));
                hs = s_awready;
                if (hs) slv_wa = s_awaddr;
            end
            P_W: begin
                chk("wdata", 64'(s_wdata), 64'(w_d[w]));
                hs = s_wready;
                if (hs) slv_mem[slv_wa] = s_wdata;
            end
            P_B: begin
                if (s_bvalid) chk("bresp", 64'(m_bresp), 64'(s_bresp));
                hs = s_bvalid & m_bready[w];
            end
            default: hs = 1'b0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run_ph(input int ph, input int w);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 40) begin
            cyc(ph, w, 1'b0, hs);
            n++;
        end
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL timeout ph%0d: no handshake in %0d cycles, want one",
                     ph, n);
        end
    endtask

    // Entered at posedge+1 with requests driven; leaves back in IDLE.
    task automatic run_txn(input int ew, input bit ewr, input int bh);
        bit hs;
        cyc(P_IDLE, ew, 1'b0, hs);
        gnt_m = ew;
        if (!ewr) begin
            run_ph(P_AR, ew);
            pend_ar[ew] = 1'b0;
            drive_m();
            run_ph(P_R, ew);
        end else begin
            run_ph(P_AW, ew);
            pend_aw[ew] = 1'b0;
            drive_m();
            run_ph(P_W, ew);
            pend_w[ew] = 1'b0;
            ref_mem[aw_a[ew]] = w_d[ew];
            drive_m();
            for (int i = 0; i < bh; i++) cyc(P_B, ew, 1'b1, hs);
            run_ph(P_B, ew);
        end
        last_m = ew;
    endtask

    function automatic int pick();
        bit r0, r1;
        r0 = pend_ar[0] | pend_aw[0];
        r1 = pend_ar[1] | pend_aw[1];
        if (r0 && r1) return 1 - last_m;
        return r0 ? 0 : 1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int w;
        bit hs;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'hA500_0000 + i;
            slv_mem[i] = 32'hA500_0000 + i;
        end
        ref_mem[8'h10] = 32'hDEAD_BEEF;
        slv_mem[8'h10] = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            ar_a[i] = '0;
            aw_a[i] = '0;
            w_d[i]  = '0;
        end

        tbl[0]  = '{2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 0, 0, 1'b0};
        tbl[1]  = '{2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 0, 1, 1'b0};
        tbl[2]  = '{2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 0, 0, 1'b0};
        tbl[3]  = '{2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 0, 1, 1'b0};
        tbl[4]  = '{2'b01, 2'b00, 8'h10, 8'h00, 0, 0, 0, 0, 1'b0};
        tbl[5]  = '{2'b00, 2'b10, 8'h00, 8'h20, 0, 32'h1234_5678, 3, 1, 1'b1};
        tbl[6]  = '{2'b01, 2'b01, 8'h30, 8'h00, 32'hCAFE_F00D, 0, 0, 0, 1'b0};
        tbl[7]  = '{2'b00, 2'b01, 8'h30, 8'h00, 32'hCAFE_F00D, 0, 0, 0, 1'b1};
        tbl[8]  = '{2'b00, 2'b11, 8'h31, 8'h32, 32'h1111_0031, 32'h2222_0032,
                    0, 1, 1'b1};
        tbl[9]  = '{2'b10, 2'b01, 8'h33, 8'h20, 32'h3333_0033, 0, 0, 0, 1'b1};
        tbl[10] = '{2'b10, 2'b11, 8'h34, 8'h32, 32'h4444_0034, 32'h5555_0032,
                    0, 1, 1'b0};
        tbl[11] = '{2'b01, 2'b10, 8'h33, 8'h35, 0, 32'h6666_0035, 0, 0, 1'b0};
        tbl[12] = '{2'b10, 2'b00, 8'h00, 8'h30, 0, 0, 0, 1, 1'b0};

        // Reset with both masters reading and the slave fully active.
        rst     = 1'b0;
        pend_ar = 2'b11;
        pend_aw = 2'b00;
        pend_w  = 2'b00;
        drive_m();
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rvalid  = 1'b1; s_bvalid  = 1'b1;
        s_rdata   = '0;   s_rresp   = 2'b00; s_bresp = 2'b00;
        m_rready  = 2'b11; m_bready = 2'b11;
        slv_ra = '0;
        slv_wa = '0;
        last_m = 1;
        gnt_m  = 0;
        #23;
        chk("reset_outs", 64'(obs()), 64'd0);
        pend_ar = 2'b00;
        drive_m();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            pend_ar = tbl[i].ar;
            pend_aw = tbl[i].aw;
            pend_w  = tbl[i].aw;
            ar_a[0] = tbl[i].a0;
            aw_a[0] = tbl[i].a0;
            ar_a[1] = tbl[i].a1;
            aw_a[1] = tbl[i].a1;
            w_d[0]  = tbl[i].d0;
            w_d[1]  = tbl[i].d1;
            drive_m();
            run_txn(tbl[i].eg, tbl[i].ewr, tbl[i].bh);
        end

        pend_ar = 2'b00;
        pend_aw = 2'b00;
        pend_w  = 2'b00;
        for (int it = 0; it < 150; it++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend_ar[m] && !pend_aw[m] && !pend_w[m]
                    && $urandom_range(0, 1) == 1) begin
                    int k;
                    k = $urandom_range(0, 2);
                    ar_a[m] = 8'($urandom_range(0, 15));
                    aw_a[m] = 8'($urandom_range(0, 15));
                    w_d[m]  = $urandom;
                    pend_ar[m] = (k != 1);
                    pend_aw[m] = (k != 0);
                    pend_w[m]  = (k != 0);
                end
            end
            if (pend_ar == 2'b00 && pend_aw == 2'b00) begin
                w = $urandom_range(0, 1);
                ar_a[w] = 8'($urandom_range(0, 15));
                pend_ar[w] = 1'b1;
            end
            drive_m();
            w = pick();
            run_txn(w, !pend_ar[w], $urandom_range(0, 2));
        end

        // Abandon a write in WDATA with an asynchronous reset.
        pend_ar = 2'b00;
        pend_aw = 2'b01;
        pend_w  = 2'b01;
        aw_a[0] = 8'h40;
        w_d[0]  = 32'h0BAD_0040;
        drive_m();
        w = pick();
        cyc(P_IDLE, w, 1'b0, hs);
        gnt_m = w;
        run_ph(P_AW, w);
        pend_aw = 2'b00;
        drive_m();
        @(negedge clk);
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rvalid  = 1'b1; s_bvalid  = 1'b1;
        m_rready  = 2'b11; m_bready = 2'b11;
        #1;
        chk("wdata_before_rst", 64'(obs()), 64'(expv(P_W, 0)));
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", 64'(obs()), 64'd0);
        @(posedge clk);
        #1;
        chk("held_rst_outs", 64'(obs()), 64'd0);
        pend_w = 2'b00;
        drive_m();
        last_m = 1;
        gnt_m  = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pend_ar = 2'b10;
        ar_a[1] = 8'h10;
        drive_m();
        run_txn(1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
